// File: rtl/hazard_stall_unit.sv
// Hazard and stall control for the 5-stage RV32 pipeline.
// Resolves load-use, multi-cycle MUL/DIV occupancy of EX and taken-branch
// redirects by driving the pipeline-register enables and flushes, and keeps
// a free-running count of cycles in which the PC was held.
module hazard_stall_unit #(
    parameter int MULDIV_LAT  = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4:0]             if_id_rs1,
    input  logic [4:0]             if_id_rs2,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [4:0]             id_ex_rd,
    input  logic                   id_ex_mem_read,
    input  logic                   ex_muldiv,
    input  logic                   ex_branch_taken,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   id_ex_write,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic                   muldiv_busy,
    output logic                   muldiv_done,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [3:0]             cnt_q;
    logic [3:0]             cnt_d;
    logic [STALL_CNT_W-1:0] stall_count_q;

    logic loadUse;
    logic mulStall;

    // A load in EX whose destination feeds a register that ID actually reads;
    // x0 is hard-wired zero so it can never be a real dependency.
    assign loadUse  = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                      ((id_rs1_used && (if_id_rs1 == id_ex_rd)) ||
                       (id_rs2_used && (if_id_rs2 == id_ex_rd)));

    // EX is held by a MUL/DIV from the cycle it arrives until the count expires.
    assign mulStall = ((state_q == IDLE) && ex_muldiv) || (state_q == BUSY);

    // MUL/DIV occupancy FSM: the arrival cycle plus LAT-1 counted BUSY cycles
    // give exactly MULDIV_LAT stalled cycles before the DONE pulse.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ex_muldiv) begin
                    cnt_d   = 4'(MULDIV_LAT - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output decode in priority order: MUL/DIV stall, then branch redirect,
    // then load-use; reset forces everything back to free-running defaults.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        muldiv_busy  = 1'b0;
        muldiv_done  = 1'b0;
        if (!rst) begin
            if (state_q == DONE) begin
                muldiv_done = 1'b1;
            end
            if (mulStall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_write  = 1'b0;
                ex_mem_flush = 1'b1;
                muldiv_busy  = 1'b1;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (loadUse) begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_ex_flush = 1'b1;
            end
        end
    end

    // State, countdown and stall counter registers with synchronous reset;
    // a reset during BUSY simply abandons the in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!pc_write) begin
                stall_count_q <= stall_count_q + STALL_CNT_W'(1);
            end
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: each directed vector pushes its
// hand-computed expected outputs, and a monitor on the falling edge pops and
// compares them against what the unit presents in that cycle.
module tb_hazard_stall_unit;

    localparam int STALL_CNT_W = 32;

    // Output vector bit order:
    // {pc_write, if_id_write, id_ex_write, if_id_flush,
    //  id_ex_flush, ex_mem_flush, muldiv_busy, muldiv_done}
    localparam logic [7:0] DEF  = 8'b1110_0000;
    localparam logic [7:0] LU   = 8'b0010_1000;
    localparam logic [7:0] BR   = 8'b1111_1000;
    localparam logic [7:0] STL  = 8'b0000_0110;
    localparam logic [7:0] DN   = 8'b1110_0001;
    localparam logic [7:0] DNLU = 8'b0010_1001;

    typedef struct {
        int          idx;
        logic [7:0]  outs;
        logic [31:0] cnt;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [4:0]             if_id_rs1 = 5'd0;
    logic [4:0]             if_id_rs2 = 5'd0;
    logic                   id_rs1_used = 1'b0;
    logic                   id_rs2_used = 1'b0;
    logic [4:0]             id_ex_rd = 5'd0;
    logic                   id_ex_mem_read = 1'b0;
    logic                   ex_muldiv = 1'b0;
    logic                   ex_branch_taken = 1'b0;
    logic                   pc_write;
    logic                   if_id_write;
    logic                   id_ex_write;
    logic                   if_id_flush;
    logic                   id_ex_flush;
    logic                   ex_mem_flush;
    logic                   muldiv_busy;
    logic                   muldiv_done;
    logic [STALL_CNT_W-1:0] stall_count;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   vecIdx = 0;
    bit   stimDone = 1'b0;

    hazard_stall_unit #(
        .MULDIV_LAT (4),
        .STALL_CNT_W(STALL_CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_ex_rd       (id_ex_rd),
        .id_ex_mem_read (id_ex_mem_read),
        .ex_muldiv      (ex_muldiv),
        .ex_branch_taken(ex_branch_taken),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_write    (id_ex_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_flush   (ex_mem_flush),
        .muldiv_busy    (muldiv_busy),
        .muldiv_done    (muldiv_done),
        .stall_count    (stall_count)
    );

    // Free-running core clock.
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected for that cycle.
    task automatic applyStimulus(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic md, input logic br,
                                 input logic [7:0] expOuts, input logic [31:0] expCnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        if_id_rs1       = rs1;
        if_id_rs2       = rs2;
        id_rs1_used     = u1;
        id_rs2_used     = u2;
        id_ex_rd        = rd;
        id_ex_mem_read  = mr;
        ex_muldiv       = md;
        ex_branch_taken = br;
        e.idx  = vecIdx;
        e.outs = expOuts;
        e.cnt  = expCnt;
        sb.push_back(e);
        vecIdx++;
    endtask

    // Compare one expected entry against the unit's current outputs.
    task automatic checkOutput(input exp_t e);
        logic [7:0] act;
        act = {pc_write, if_id_write, id_ex_write, if_id_flush,
               id_ex_flush, ex_mem_flush, muldiv_busy, muldiv_done};
        checks++;
        if (act === e.outs) begin
            passes++;
        end else begin
            $display("[TB] FAIL outs vec%0d: got %b expected %b", e.idx, act, e.outs);
        end
        checks++;
        if (stall_count === e.cnt) begin
            passes++;
        end else begin
            $display("[TB] FAIL stall_count vec%0d: got %0d expected %0d", e.idx, stall_count, e.cnt);
        end
    endtask

    // Monitor: every falling edge, pop and check the pending expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                checkOutput(sb.pop_front());
            end
        end
    end

    // Directed vectors: r, rs1, rs2, u1, u2, rd, memRead, muldiv, branch, outs, count.
    initial begin
        @(posedge clk);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        // load-use on rs1, then released
        applyStimulus(0, 5, 0, 1, 0, 5, 1, 0, 0, LU,  0);
        applyStimulus(0, 5, 0, 1, 0, 5, 0, 0, 0, DEF, 1);
        // operand not used, and x0
        applyStimulus(0, 5, 0, 0, 0, 5, 1, 0, 0, DEF, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 1, 0, 0, DEF, 1);
        // load-use on rs2
        applyStimulus(0, 1, 7, 0, 1, 7, 1, 0, 0, LU,  1);
        applyStimulus(0, 1, 7, 0, 1, 7, 0, 0, 0, DEF, 2);
        // branch beats load-use
        applyStimulus(0, 5, 0, 1, 0, 5, 1, 0, 1, BR,  2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2);
        // MUL/DIV: four stalled cycles, done, ex_muldiv ignored in DONE
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 5);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, DN,  6);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 6);
        // back-to-back MUL/DIV, second one entering right after DONE
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 6);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 8);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 9);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, DN,  10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 10);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 11);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 12);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 13);
        // load-use still applies in DONE
        applyStimulus(0, 5, 0, 1, 0, 5, 1, 1, 0, DNLU, 14);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 15);
        // reset at cycle 2 of a MUL/DIV
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 15);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 16);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 17);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        // MUL/DIV stall overrides a taken branch
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, STL, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, STL, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
        stimDone = 1'b1;
    end

    // Wait for the scoreboard to drain within a bounded number of cycles,
    // then report.
    initial begin
        wait (stimDone);
        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        checks++;
        if (sb.size() == 0) begin
            passes++;
        end else begin
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
